// File: rtl/mem_stage.sv
// mem_stage: memory stage of the 5-stage MIPS pipeline.
//
// Takes the EX/MEM pipeline register, performs lw/sw accesses over a req/ack
// data-memory handshake, and produces the MEM/WB pipeline register. While an
// access is outstanding mem_stall_c holds EX and the upstream stages.
//
// Ports:
//   clock, reset_n         clock; synchronous active-low reset
//   EX_MEM_*               incoming pipeline register (result = byte address for lw/sw)
//   dmem_req/we/addr/wdata registered memory request (addr word aligned)
//   dmem_ack, dmem_rdata   memory completion and read data
//   mem_stall_c            combinational stall to EX
//   MEM_WB_*               outgoing pipeline register; err flags misalign/timeout
module mem_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 255  // legal range 1..255
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] EX_MEM_result,
    input  logic [31:0] EX_MEM_B,
    input  logic [4:0]  EX_MEM_dest,
    input  logic [5:0]  EX_MEM_op,
    input  logic        EX_MEM_valid,
    input  logic [31:0] EX_MEM_targetPC,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic        mem_stall_c,
    output logic [31:0] MEM_WB_result,
    output logic [4:0]  MEM_WB_dest,
    output logic [5:0]  MEM_WB_op,
    output logic        MEM_WB_valid,
    output logic [31:0] MEM_WB_targetPC,
    output logic        MEM_WB_err
);

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [7:0] LAST_CNT = 8'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

    state_e      state_q;
    logic [7:0]  cnt_q;
    logic [31:0] rdata_q;
    logic        err_q;

    logic is_lw, is_sw, is_mem, aligned;

    assign is_lw   = (EX_MEM_op == OP_LW);
    assign is_sw   = (EX_MEM_op == OP_SW);
    assign is_mem  = is_lw | is_sw;
    assign aligned = (EX_MEM_result[1:0] == 2'b00);

    // Depends on state and the EX_MEM instruction only, never on dmem_ack.
    // Gated by reset so every output reads 0 while reset is held.
    always_comb begin
        mem_stall_c = reset_n &&
                      ((state_q == StWait) || ((state_q == StIdle) && is_mem && aligned));
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q         <= StIdle;
            cnt_q           <= 8'd0;
            rdata_q         <= 32'd0;
            err_q           <= 1'b0;
            dmem_req        <= 1'b0;
            dmem_we         <= 1'b0;
            dmem_addr       <= 32'd0;
            dmem_wdata      <= 32'd0;
            MEM_WB_result   <= 32'd0;
            MEM_WB_dest     <= 5'd0;
            MEM_WB_op       <= 6'd0;
            MEM_WB_valid    <= 1'b0;
            MEM_WB_targetPC <= 32'd0;
            MEM_WB_err      <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    MEM_WB_dest     <= EX_MEM_dest;
                    MEM_WB_op       <= EX_MEM_op;
                    MEM_WB_targetPC <= EX_MEM_targetPC;
                    if (is_mem && aligned) begin
                        state_q       <= StWait;
                        cnt_q         <= 8'd0;
                        dmem_req      <= 1'b1;
                        dmem_we       <= is_sw;
                        dmem_addr     <= {EX_MEM_result[31:2], 2'b00};
                        dmem_wdata    <= EX_MEM_B;
                        // Bubble into WB while the access is in flight.
                        MEM_WB_result <= 32'd0;
                        MEM_WB_valid  <= 1'b0;
                        MEM_WB_err    <= 1'b0;
                    end else begin
                        // Misaligned memory ops fault here without touching memory.
                        MEM_WB_result <= is_mem ? 32'd0 : EX_MEM_result;
                        MEM_WB_valid  <= is_mem ? 1'b0 : EX_MEM_valid;
                        MEM_WB_err    <= is_mem;
                    end
                end
                StWait: begin
                    if (dmem_ack) begin
                        rdata_q  <= dmem_rdata;
                        err_q    <= 1'b0;
                        dmem_req <= 1'b0;
                        state_q  <= StDone;
                    end else if (cnt_q == LAST_CNT) begin
                        err_q    <= 1'b1;
                        dmem_req <= 1'b0;
                        state_q  <= StDone;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                StDone: begin
                    // EX_MEM still holds the memory instruction here; it is retired, not re-issued.
                    state_q         <= StIdle;
                    MEM_WB_dest     <= EX_MEM_dest;
                    MEM_WB_op       <= EX_MEM_op;
                    MEM_WB_targetPC <= EX_MEM_targetPC;
                    MEM_WB_result   <= (is_lw && !err_q) ? rdata_q : 32'd0;
                    MEM_WB_valid    <= is_lw && !err_q;
                    MEM_WB_err      <= err_q;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

    localparam int unsigned T = 4;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_ADD = 6'b000000;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] EX_MEM_result = '0, EX_MEM_B = '0, EX_MEM_targetPC = '0;
    logic [4:0]  EX_MEM_dest = '0;
    logic [5:0]  EX_MEM_op = '0;
    logic        EX_MEM_valid = 1'b0;
    logic        dmem_ack = 1'b0;
    logic [31:0] dmem_rdata = '0;
    logic        dmem_req, dmem_we, mem_stall_c, MEM_WB_valid, MEM_WB_err;
    logic [31:0] dmem_addr, dmem_wdata, MEM_WB_result, MEM_WB_targetPC;
    logic [4:0]  MEM_WB_dest;
    logic [5:0]  MEM_WB_op;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int first_req_cyc = 0;
    int last_req_cyc = 0;

    mem_stage #(.TIMEOUT_CYCLES(T)) dut (
        .clock(clock), .reset_n(reset_n),
        .EX_MEM_result(EX_MEM_result), .EX_MEM_B(EX_MEM_B), .EX_MEM_dest(EX_MEM_dest),
        .EX_MEM_op(EX_MEM_op), .EX_MEM_valid(EX_MEM_valid), .EX_MEM_targetPC(EX_MEM_targetPC),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .mem_stall_c(mem_stall_c),
        .MEM_WB_result(MEM_WB_result), .MEM_WB_dest(MEM_WB_dest), .MEM_WB_op(MEM_WB_op),
        .MEM_WB_valid(MEM_WB_valid), .MEM_WB_targetPC(MEM_WB_targetPC), .MEM_WB_err(MEM_WB_err)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    // Drives one instruction (called #1 after a posedge) and checks it against
    // the rules: access length, stall length, request stability, MEM_WB result.
    // ack_after: WAIT cycle (1-based) in which memory acks; 0 means never.
    task automatic run_op(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] b,
                          input logic [4:0] dest, input logic valid, input logic [31:0] tpc,
                          input int ack_after, input logic [31:0] rdata, input string name);
        bit          is_mem, aligned, ok;
        int          exp_req, exp_stall, req_n, stall_n, bad, n;
        logic [31:0] exp_res;
        logic        exp_valid, exp_err;
        bit          done;
        is_mem  = (op == OP_LW) || (op == OP_SW);
        aligned = (addr % 4) == 0;
        ok      = (ack_after >= 1) && (ack_after <= int'(T));
        if (!is_mem) begin
            exp_req = 0; exp_stall = 0; exp_res = addr; exp_valid = valid; exp_err = 0;
        end else if (!aligned) begin
            exp_req = 0; exp_stall = 0; exp_res = 0; exp_valid = 0; exp_err = 1;
        end else begin
            exp_req   = ok ? ack_after : int'(T);
            exp_stall = exp_req + 1;
            exp_err   = !ok;
            exp_valid = (op == OP_LW) && ok;
            exp_res   = exp_valid ? rdata : 32'd0;
        end
        EX_MEM_op = op; EX_MEM_result = addr; EX_MEM_B = b; EX_MEM_dest = dest;
        EX_MEM_valid = valid; EX_MEM_targetPC = tpc;
        req_n = 0; stall_n = 0; bad = 0; n = 0; done = 0;
        while (!done && n < 300) begin
            @(negedge clock);
            n++;
            if (mem_stall_c) stall_n++;
            if (dmem_req) begin
                req_n++;
                if (req_n == 1) first_req_cyc = cyc;
                last_req_cyc = cyc;
                if (dmem_addr !== (addr & 32'hFFFF_FFFC) || dmem_we !== (op == OP_SW) ||
                    dmem_wdata !== b) bad++;
                if (req_n == ack_after) begin
                    dmem_ack = 1'b1;
                    dmem_rdata = rdata;
                end
            end
            if (!mem_stall_c) done = 1;
            @(posedge clock);
            #1;
            dmem_ack = 1'b0;
            dmem_rdata = $urandom;
        end
        tests++;
        if (!done) begin
            fails++;
            $display("FAIL %s completion: stall still high after %0d cycles, required drop", name, n);
        end
        tests++;
        if (req_n !== exp_req) begin
            fails++;
            $display("FAIL %s req_cycles: got %0d, expected %0d", name, req_n, exp_req);
        end
        tests++;
        if (stall_n !== exp_stall) begin
            fails++;
            $display("FAIL %s stall_cycles: got %0d, expected %0d", name, stall_n, exp_stall);
        end
        tests++;
        if (bad !== 0) begin
            fails++;
            $display("FAIL %s req_stable: %0d bad cycles, expected 0", name, bad);
        end
        tests++;
        if ({MEM_WB_result, MEM_WB_valid, MEM_WB_err} !== {exp_res, exp_valid, exp_err}) begin
            fails++;
            $display("FAIL %s mem_wb: got res=%h v=%b e=%b, expected res=%h v=%b e=%b", name,
                     MEM_WB_result, MEM_WB_valid, MEM_WB_err, exp_res, exp_valid, exp_err);
        end
        tests++;
        if ({MEM_WB_dest, MEM_WB_op, MEM_WB_targetPC} !== {dest, op, tpc}) begin
            fails++;
            $display("FAIL %s passthru: got d=%0d op=%h pc=%h, expected d=%0d op=%h pc=%h", name,
                     MEM_WB_dest, MEM_WB_op, MEM_WB_targetPC, dest, op, tpc);
        end
    endtask

    function automatic logic [5:0] rand_alu_op();
        logic [5:0] op;
        op = 6'($urandom_range(0, 63));
        while (op == OP_LW || op == OP_SW) op = 6'($urandom_range(0, 63));
        return op;
    endfunction

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        tests++;
        if ({dmem_req, dmem_we, dmem_addr, dmem_wdata, mem_stall_c} !== '0) begin
            fails++;
            $display("FAIL reset_dmem: got req=%b we=%b addr=%h wdata=%h stall=%b, expected all 0",
                     dmem_req, dmem_we, dmem_addr, dmem_wdata, mem_stall_c);
        end
        tests++;
        if ({MEM_WB_result, MEM_WB_dest, MEM_WB_op, MEM_WB_valid, MEM_WB_targetPC,
             MEM_WB_err} !== '0) begin
            fails++;
            $display("FAIL reset_mem_wb: got res=%h d=%0d op=%h v=%b pc=%h e=%b, expected all 0",
                     MEM_WB_result, MEM_WB_dest, MEM_WB_op, MEM_WB_valid, MEM_WB_targetPC,
                     MEM_WB_err);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_alu();
        run_op(OP_ADD, 32'h5, 32'h0, 5'd3, 1'b1, 32'h40, 0, 32'h0, "add_directed");
        for (int i = 0; i < 6; i++)
            run_op(rand_alu_op(), $urandom, $urandom, 5'($urandom), 1'($urandom), $urandom,
                   0, 32'h0, "alu_rand");
    endtask

    task automatic test_lw();
        run_op(OP_LW, 32'h100, 32'h0, 5'd8, 1'b1, 32'h44, 1, 32'hDEAD_BEEF, "lw_directed");
        for (int i = 0; i < 4; i++)
            run_op(OP_LW, $urandom & 32'hFFFF_FFFC, $urandom, 5'($urandom), 1'b1, $urandom,
                   int'($urandom_range(1, T)), $urandom, "lw_rand");
    endtask

    task automatic test_sw();
        run_op(OP_SW, 32'h204, 32'h1234_5678, 5'd0, 1'b0, 32'h48, 3, 32'hFFFF_FFFF, "sw_directed");
        for (int i = 0; i < 3; i++)
            run_op(OP_SW, $urandom & 32'hFFFF_FFFC, $urandom, 5'($urandom), 1'($urandom),
                   $urandom, int'($urandom_range(1, T)), $urandom, "sw_rand");
    endtask

    task automatic test_misaligned();
        run_op(OP_LW, 32'h102, 32'h0, 5'd9, 1'b1, 32'h4C, 1, 32'h0, "lw_misaligned");
        for (int i = 0; i < 3; i++)
            run_op((i % 2 == 0) ? OP_SW : OP_LW, ($urandom & 32'hFFFF_FFFC) | 32'(i % 3 + 1),
                   $urandom, 5'($urandom), 1'b1, $urandom, 1, $urandom, "mem_misaligned");
    endtask

    task automatic test_timeout();
        run_op(OP_LW, 32'h300, 32'h0, 5'd4, 1'b1, 32'h50, 0, 32'h0, "lw_timeout");
        run_op(OP_ADD, 32'h77, 32'h0, 5'd6, 1'b1, 32'h54, 0, 32'h0, "add_after_timeout");
        run_op(OP_SW, 32'h308, 32'hA5A5_5A5A, 5'd0, 1'b0, 32'h58, 0, 32'h0, "sw_timeout");
        run_op(OP_LW, 32'h30C, 32'h0, 5'd7, 1'b1, 32'h5C, int'(T), 32'hCAFE_F00D, "lw_ack_last");
    endtask

    task automatic test_back_to_back();
        int prev_last;
        run_op(OP_LW, 32'h400, 32'h0, 5'd10, 1'b1, 32'h60, 1, $urandom, "b2b_lw1");
        prev_last = last_req_cyc;
        run_op(OP_LW, 32'h404, 32'h0, 5'd11, 1'b1, 32'h64, 2, $urandom, "b2b_lw2");
        tests++;
        if (first_req_cyc - prev_last - 1 < 2) begin
            fails++;
            $display("FAIL b2b_gap: req low for %0d cycles, required at least 2",
                     first_req_cyc - prev_last - 1);
        end
    endtask

    task automatic test_reset_midflight();
        int          seen, n;
        logic [31:0] r;
        EX_MEM_op = OP_LW; EX_MEM_result = 32'h500; EX_MEM_dest = 5'd12; EX_MEM_valid = 1'b1;
        EX_MEM_targetPC = 32'h68;
        seen = 0; n = 0;
        while (seen < 2 && n < 20) begin
            @(negedge clock);
            n++;
            if (dmem_req) seen++;
            if (seen == 2) reset_n = 1'b0;
            else begin
                @(posedge clock);
                #1;
            end
        end
        tests++;
        if (seen < 2) begin
            fails++;
            $display("FAIL rst_mid_reach: saw %0d request cycles, required 2", seen);
        end
        @(posedge clock);
        #1;
        tests++;
        if ({dmem_req, mem_stall_c} !== 2'b00) begin
            fails++;
            $display("FAIL rst_mid_dmem: got req=%b stall=%b, expected 0 0", dmem_req, mem_stall_c);
        end
        tests++;
        if ({MEM_WB_result, MEM_WB_dest, MEM_WB_op, MEM_WB_valid, MEM_WB_targetPC,
             MEM_WB_err} !== '0) begin
            fails++;
            $display("FAIL rst_mid_mem_wb: got res=%h d=%0d v=%b e=%b, expected all 0",
                     MEM_WB_result, MEM_WB_dest, MEM_WB_valid, MEM_WB_err);
        end
        // Late ack after reset, with an ALU op now in EX_MEM: must be ignored.
        r = $urandom;
        EX_MEM_op = OP_ADD; EX_MEM_result = r; EX_MEM_dest = 5'd13; EX_MEM_valid = 1'b1;
        dmem_ack = 1'b1; dmem_rdata = ~r;
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        dmem_ack = 1'b0;
        tests++;
        if ({dmem_req, MEM_WB_result, MEM_WB_valid, MEM_WB_err} !== {1'b0, r, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL rst_late_ack: got req=%b res=%h v=%b e=%b, expected 0 %h 1 0",
                     dmem_req, MEM_WB_result, MEM_WB_valid, MEM_WB_err, r);
        end
        run_op(OP_LW, 32'h600, 32'h0, 5'd14, 1'b1, 32'h6C, 2, 32'h1357_9BDF, "lw_after_reset");
    endtask

    initial begin
        test_reset();
        @(posedge clock);
        #1;
        test_alu();
        test_lw();
        test_sw();
        test_misaligned();
        test_timeout();
        test_back_to_back();
        test_reset_midflight();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory stage of the 5-stage MIPS pipeline. Consumes the EX/MEM pipeline register, performs `lw`/`sw` accesses to the data memory over a req/ack handshake, and produces the MEM/WB pipeline register. Drives `mem_stall_c` so EX, and therefore the upstream stages, hold while an access is outstanding.

## Interface
- `TIMEOUT_CYCLES`, default 255: max cycles `dmem_req` is held without `dmem_ack` before the access is aborted. Legal range 1..255.
- `clock` in 1: clock.
- `reset_n` in 1: reset, synchronous, active-low.
- `EX_MEM_result` in 32: ALU result. For `lw`/`sw` this is the byte effective address, computed by EX as A+imm.
- `EX_MEM_B` in 32: store data.
- `EX_MEM_dest` in 5: destination register.
- `EX_MEM_op` in 6: opcode.
- `EX_MEM_valid` in 1: result writes the register file.
- `EX_MEM_targetPC` in 32: next/target PC, passed through.
- `dmem_ack` in 1: memory completes the current request.
- `dmem_rdata` in 32: read data. Valid when `dmem_ack`=1.
- `dmem_req` out 1: request. Registered.
- `dmem_we` out 1: 1 means store. Registered.
- `dmem_addr` out 32: word-aligned address. Registered.
- `dmem_wdata` out 32: store data. Registered.
- `mem_stall_c` out 1: stall to EX. Combinational from state and `EX_MEM_op` only, never from `dmem_ack`.
- `MEM_WB_result` out 32: writeback data.
- `MEM_WB_dest` out 5: destination register.
- `MEM_WB_op` out 6: opcode.
- `MEM_WB_valid` out 1: write enable for WB.
- `MEM_WB_targetPC` out 32: passed through.
- `MEM_WB_err` out 1: access fault (misaligned or timeout).

## Operation
- Opcodes: `lw`=6'b100011, `sw`=6'b101011. All other opcodes are non-memory.
- Non-memory ops take one cycle. Every cycle in IDLE, MEM_WB captures `result`/`dest`/`op`/`valid`/`targetPC` from EX_MEM, and `err`=0.
- FSM states: IDLE, WAIT, DONE.
- **IDLE, `is_mem`=1, address aligned (`EX_MEM_result[1:0]`==0):**
  - `mem_stall_c`=1.
  - Next cycle: state WAIT, `dmem_req`=1, `dmem_we`=(op==`sw`), `dmem_addr`={result[31:2],2'b00}, `dmem_wdata`=`EX_MEM_B`, wait counter cleared to 0.
- **IDLE, `is_mem`=1, misaligned:**
  - No request is issued and `mem_stall_c`=0.
  - MEM_WB gets `valid`=0, `err`=1, `result`=0, `dest`/`op`/`targetPC` passed through.
  - State stays IDLE.
- **WAIT:**
  - `mem_stall_c`=1 and `dmem_req` is held with address, data and `we` stable.
  - On `dmem_ack`=1: latch `dmem_rdata` into the internal `rdata_q`, drop `dmem_req` next cycle, go to DONE with `err_q`=0.
  - Otherwise the counter increments. When the counter is `TIMEOUT_CYCLES`-1 and still no ack: drop `dmem_req`, go to DONE with `err_q`=1.
- **DONE:**
  - `mem_stall_c`=0, so EX advances at this edge.
  - For `lw` without error, MEM_WB gets `result`=`rdata_q`, `valid`=1, `dest`=`EX_MEM_dest`.
  - For `sw`, `result`=0 and `valid`=0.
  - On error, `valid`=0, `err`=1, `result`=0.
  - Next state is IDLE.
  - The instruction still sitting in EX_MEM during DONE is not re-issued.
- `dmem_ack` outside WAIT is ignored.
- Reset, any state: state goes to IDLE, counter to 0, and every output is 0, including `dmem_req`. An in-flight request is abandoned with no MEM_WB update.

## Timing
- Non-memory op: 1 cycle in MEM. MEM_WB is valid at the edge after EX_MEM.
- Memory op, ack in the first WAIT cycle: 3 cycles in MEM (IDLE, WAIT, DONE). `mem_stall_c` is high for 2 cycles.
- Each extra WAIT cycle adds one cycle of latency and one cycle of stall.
- Timeout: `dmem_req` is high for exactly `TIMEOUT_CYCLES` cycles.
- Back-to-back `lw`s: the second enters IDLE the cycle after DONE. There is no bubble beyond the FSM, and `dmem_req` drops for at least 2 cycles between requests.
- Reset value of every output is 0.

## Test plan
- Reset, then `add` with result=0x0000_0005, dest=3, valid=1 → next edge MEM_WB `result`=5, `dest`=3, `valid`=1; `mem_stall_c` never asserts.
- `lw` with addr=0x100, dest=8, ack in the first WAIT cycle with rdata=0xDEAD_BEEF → `dmem_req`/`dmem_addr`=0x100 for 1 cycle, stall for 2 cycles, then MEM_WB `result`=0xDEADBEEF, `valid`=1, `dest`=8.
- `sw` with addr=0x204, B=0x1234_5678, ack after 3 WAIT cycles → `dmem_we`=1 and `dmem_wdata`=0x12345678 stable for 3 cycles, stall for 4 cycles, then MEM_WB `valid`=0, `err`=0.
- `lw` with addr=0x102 → no `dmem_req`, no stall; MEM_WB `err`=1, `valid`=0.
- `TIMEOUT_CYCLES`=4 and no ack → `dmem_req` high for 4 cycles; MEM_WB `err`=1, `valid`=0; a following `add` completes normally.
- `reset_n`=0 during the second WAIT cycle of a `lw` → the next cycle `dmem_req`=0, `mem_stall_c`=0 and all MEM_WB fields are 0; a late `dmem_ack` is ignored.
